cga_fetch_seq: RTL and testbench

CGA_FETCH_SEQ -- requirements
Module: cga_fetch_seq

---
 rtl/cga_fetch_seq.sv | 212 +++++++++++++++++++++
 tb/tb_cga_fetch_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cga_fetch_seq.sv
// ---------------------------------------------------------------------------
// cga_fetch_seq
//
// Character-slot sequencer for a CGA-style display controller. A free-running
// 5-bit count (clk_seq) is divided into 16 slot phases. In high-res timing each
// phase lasts one clk, so one character takes 16 clk. In low-res timing each
// phase lasts two clk, so one character takes 32 clk. Display fetch strobes are
// issued on the first clk of fixed phases. The CPU gets the VRAM bus for a
// 4-clk window that starts on the first clk of phase 8. This window never
// meets the display fetch window at phases 1..5.
//
// Ports
//   clk            in   pixel clock, rising edge active
//   reset_n        in   asynchronous active-low reset
//   hres_mode      in   high-res timing request (sampled at clk_seq==31)
//   video_enabled  in   display fetch enable
//   cpu_req        in   one-cycle ISA VRAM access request
//   clk_seq        out  [4:0] free-running sequence count
//   crtc_clk       out  character-clock enable to CRTC (phase 15)
//   vram_read      out  VRAM output-enable for display fetch (phases 1..5)
//   vram_read_char out  character byte latch strobe (phase 2)
//   vram_read_att  out  attribute byte latch strobe (phase 4)
//   charrom_read   out  character ROM lookup strobe (phase 6)
//   disp_pipeline  out  attribute/cursor pipeline advance (phase 14)
//   cpu_sel        out  VRAM address/data mux owned by the CPU
//   cpu_wait       out  ISA wait while a request is outstanding
//   cpu_done       out  last cycle of the CPU slot
//
// Every output is a flop. The next value of each output is decoded from the
// next values of the sequence count, the effective mode and the arbiter
// state. This keeps each registered output aligned with the clk_seq value
// that it belongs to.
// ---------------------------------------------------------------------------
module cga_fetch_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hres_mode,
  input  logic       video_enabled,
  input  logic       cpu_req,
  output logic [4:0] clk_seq,
  output logic       crtc_clk,
  output logic       vram_read,
  output logic       vram_read_char,
  output logic       vram_read_att,
  output logic       charrom_read,
  output logic       disp_pipeline,
  output logic       cpu_sel,
  output logic       cpu_wait,
  output logic       cpu_done
);

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_PEND   = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

  // Slot phases used by the sequencer
  localparam logic [3:0] PH_CHAR    = 4'd2;
  localparam logic [3:0] PH_ATT     = 4'd4;
  localparam logic [3:0] PH_CHARROM = 4'd6;
  localparam logic [3:0] PH_CPU     = 4'd8;
  localparam logic [3:0] PH_DISP    = 4'd14;
  localparam logic [3:0] PH_CRTC    = 4'd15;
  localparam logic [3:0] PH_RD_LO   = 4'd1;
  localparam logic [3:0] PH_RD_HI   = 4'd5;

  // Slot phase for a given count and mode. In low-res each phase spans two
  // counts.
  function automatic logic [3:0] phase_of(input logic [4:0] seq, input logic hres);
    phase_of = hres ? seq[3:0] : seq[4:1];
  endfunction

  // In high-res every count is a phase start. In low-res only even counts are.
  function automatic logic phase_start(input logic [4:0] seq, input logic hres);
    phase_start = hres | ~seq[0];
  endfunction

  logic [4:0]  clk_seq_r;
  logic        hres_eff_r;
  arb_state_t  state_r;
  logic [1:0]  acc_cnt_r;

  logic        crtc_clk_r;
  logic        vram_read_r;
  logic        vram_read_char_r;
  logic        vram_read_att_r;
  logic        charrom_read_r;
  logic        disp_pipeline_r;
  logic        cpu_sel_r;
  logic        cpu_wait_r;
  logic        cpu_done_r;

  logic [4:0]  seq_nxt_s;
  logic        hres_nxt_s;
  logic [3:0]  ph_nxt_s;
  logic        first_nxt_s;
  arb_state_t  state_nxt_s;
  logic [1:0]  acc_cnt_nxt_s;

  // Next count and effective mode. The mode can only change across the 31->0
  // wrap, so a character is never split between two timings.
  always_comb begin
    seq_nxt_s   = clk_seq_r + 5'd1;
    hres_nxt_s  = hres_eff_r;
    if (clk_seq_r == 5'd31) begin
      hres_nxt_s = hres_mode;
    end else begin
      hres_nxt_s = hres_eff_r;
    end
    ph_nxt_s    = phase_of(seq_nxt_s, hres_nxt_s);
    first_nxt_s = phase_start(seq_nxt_s, hres_nxt_s);
  end

  // CPU arbiter next state. A grant is issued so that the first ACCESS cycle
  // is the first clk of phase 8, or right away when display fetch is off.
  // Requests that arrive outside IDLE are dropped, because the ISA cycle is
  // held by cpu_wait.
  always_comb begin
    state_nxt_s   = state_r;
    acc_cnt_nxt_s = acc_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (cpu_req) begin
          state_nxt_s = ARB_PEND;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
        acc_cnt_nxt_s = 2'd0;
      end
      ARB_PEND: begin
        if (!video_enabled || (first_nxt_s && (ph_nxt_s == PH_CPU))) begin
          state_nxt_s   = ARB_ACCESS;
          acc_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s   = ARB_PEND;
          acc_cnt_nxt_s = 2'd0;
        end
      end
      ARB_ACCESS: begin
        if (acc_cnt_r == 2'd3) begin
          state_nxt_s   = ARB_IDLE;
          acc_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s   = ARB_ACCESS;
          acc_cnt_nxt_s = acc_cnt_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s   = ARB_IDLE;
        acc_cnt_nxt_s = 2'd0;
      end
    endcase
  end

  // Sequence count, effective mode and arbiter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_seq_r  <= 5'd0;
      hres_eff_r <= 1'b0;
      state_r    <= ARB_IDLE;
      acc_cnt_r  <= 2'd0;
    end else begin
      clk_seq_r  <= seq_nxt_s;
      hres_eff_r <= hres_nxt_s;
      state_r    <= state_nxt_s;
      acc_cnt_r  <= acc_cnt_nxt_s;
    end
  end

  // Registered strobes and CPU handshake outputs. Each one is decoded from the
  // next-cycle values, so it appears together with the clk_seq it belongs to.
  // vram_read is also held low while display fetch is off or the CPU owns
  // the bus. This keeps the two VRAM bus masters exclusive even when
  // video_enabled changes in the middle of a slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crtc_clk_r       <= 1'b0;
      vram_read_r      <= 1'b0;
      vram_read_char_r <= 1'b0;
      vram_read_att_r  <= 1'b0;
      charrom_read_r   <= 1'b0;
      disp_pipeline_r  <= 1'b0;
      cpu_sel_r        <= 1'b0;
      cpu_wait_r       <= 1'b0;
      cpu_done_r       <= 1'b0;
    end else begin
      crtc_clk_r       <= first_nxt_s && (ph_nxt_s == PH_CRTC);
      vram_read_r      <= video_enabled && (state_nxt_s != ARB_ACCESS) &&
                          (ph_nxt_s >= PH_RD_LO) && (ph_nxt_s <= PH_RD_HI);
      vram_read_char_r <= video_enabled && first_nxt_s && (ph_nxt_s == PH_CHAR);
      vram_read_att_r  <= video_enabled && first_nxt_s && (ph_nxt_s == PH_ATT);
      charrom_read_r   <= first_nxt_s && (ph_nxt_s == PH_CHARROM);
      disp_pipeline_r  <= first_nxt_s && (ph_nxt_s == PH_DISP);
      cpu_sel_r        <= (state_nxt_s == ARB_ACCESS);
      cpu_wait_r       <= (state_nxt_s != ARB_IDLE);
      cpu_done_r       <= (state_nxt_s == ARB_ACCESS) && (acc_cnt_nxt_s == 2'd3);
    end
  end

  assign clk_seq        = clk_seq_r;
  assign crtc_clk       = crtc_clk_r;
  assign vram_read      = vram_read_r;
  assign vram_read_char = vram_read_char_r;
  assign vram_read_att  = vram_read_att_r;
  assign charrom_read   = charrom_read_r;
  assign disp_pipeline  = disp_pipeline_r;
  assign cpu_sel        = cpu_sel_r;
  assign cpu_wait       = cpu_wait_r;
  assign cpu_done       = cpu_done_r;

endmodule

// File: tb/tb_cga_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_cga_fetch_seq
//
// Directed self-checking bench for cga_fetch_seq. Inputs are driven and
// outputs are sampled on the falling clock edge. The expected strobe
// positions are hand-listed clk_seq values for each timing mode.
// ---------------------------------------------------------------------------
module tb_cga_fetch_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hres_mode;
  logic       video_enabled;
  logic       cpu_req;
  logic [4:0] clk_seq;
  logic       crtc_clk;
  logic       vram_read;
  logic       vram_read_char;
  logic       vram_read_att;
  logic       charrom_read;
  logic       disp_pipeline;
  logic       cpu_sel;
  logic       cpu_wait;
  logic       cpu_done;

  int n_tests = 0;
  int n_fail  = 0;

  cga_fetch_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hres_mode      (hres_mode),
    .video_enabled  (video_enabled),
    .cpu_req        (cpu_req),
    .clk_seq        (clk_seq),
    .crtc_clk       (crtc_clk),
    .vram_read      (vram_read),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .cpu_sel        (cpu_sel),
    .cpu_wait       (cpu_wait),
    .cpu_done       (cpu_done)
  );

  // 10-unit pixel clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {crtc, vram_read, char, att, charrom, disp} for a clk_seq value
  function automatic logic [5:0] exp_strobes(input int s, input logic hres, input logic ven);
    logic c, r, ch, at, cr, dp;
    if (hres) begin
      c  = (s == 15) || (s == 31);
      r  = ven && (((s >= 1) && (s <= 5)) || ((s >= 17) && (s <= 21)));
      ch = ven && ((s == 2) || (s == 18));
      at = ven && ((s == 4) || (s == 20));
      cr = (s == 6) || (s == 22);
      dp = (s == 14) || (s == 30);
    end else begin
      c  = (s == 30);
      r  = ven && (s >= 2) && (s <= 11);
      ch = ven && (s == 4);
      at = ven && (s == 8);
      cr = (s == 12);
      dp = (s == 28);
    end
    exp_strobes = {c, r, ch, at, cr, dp};
  endfunction

  // Advance to the next falling edge where clk_seq equals target, bounded
  task automatic wait_seq(input int target);
    int k;
    k = 0;
    while ((clk_seq !== target[4:0]) && (k < 64)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 64) check("wait_seq_timeout", {27'd0, clk_seq}, target);
  endtask

  // Check count and strobes for clk_seq from..to in the given mode
  task automatic scan(input logic hres, input int from, input int to, input string tag);
    for (int s = from; s <= to; s++) begin
      check({tag, "_seq"}, {27'd0, clk_seq}, s);
      check(tag, {26'd0, crtc_clk, vram_read, vram_read_char, vram_read_att,
                  charrom_read, disp_pipeline},
            {26'd0, exp_strobes(s, hres, video_enabled)});
      @(negedge clk);
    end
  endtask

  // Check {cpu_wait, cpu_sel, cpu_done} against hand-placed windows
  task automatic cpu_window(input int from, input int to, input int sel_lo,
                            input int sel_hi, input int wait_lo, input int wait_hi,
                            input string tag);
    logic [2:0] e;
    for (int s = from; s <= to; s++) begin
      e = {(s >= wait_lo) && (s <= wait_hi), (s >= sel_lo) && (s <= sel_hi), s == sel_hi};
      check({tag, "_seq"}, {27'd0, clk_seq}, s);
      check(tag, {29'd0, cpu_wait, cpu_sel, cpu_done}, {29'd0, e});
      check({tag, "_excl"}, {31'd0, cpu_sel & vram_read}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int sel_cnt;
    int done_cnt;
    reset_n = 1'b1; hres_mode = 1'b0; video_enabled = 1'b0; cpu_req = 1'b0;
    #1 reset_n = 1'b0;
    #10;
    check("reset_state", {18'd0, clk_seq, crtc_clk, vram_read, vram_read_char, vram_read_att,
                          charrom_read, disp_pipeline, cpu_sel, cpu_wait, cpu_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("seq_after_reset", {27'd0, clk_seq}, 32'd1);

    // The high-res request takes effect only after the first wrap
    hres_mode = 1'b1; video_enabled = 1'b1;
    wait_seq(0);
    scan(1'b1, 0, 31, "hres_frame");
    scan(1'b1, 0, 9, "hres_pre");
    hres_mode = 1'b0;
    scan(1'b1, 10, 31, "hres_hold");
    scan(1'b0, 0, 31, "lres_frame");
    scan(1'b0, 0, 9, "lres_pre");
    hres_mode = 1'b1;
    scan(1'b0, 10, 20, "lres_glitch");
    hres_mode = 1'b0;
    scan(1'b0, 21, 31, "lres_glitch_end");
    hres_mode = 1'b1;
    scan(1'b0, 0, 31, "lres_last");
    scan(1'b1, 0, 2, "hres_again");

    // Request at clk_seq 3 with display fetch on
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_window(4, 13, 8, 11, 4, 11, "cpu_hres");

    // Extra requests during PEND and on the cpu_done cycle are dropped
    wait_seq(3);
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    sel_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cpu_req = (clk_seq == 5'd11);
      sel_cnt += int'(cpu_sel);
      done_cnt += int'(cpu_done);
      if ((clk_seq == 5'd12) && (k < 10)) check("dup_wait_release", {31'd0, cpu_wait}, 32'd0);
      @(negedge clk);
    end
    cpu_req = 1'b0;
    check("dup_sel_cycles", sel_cnt, 32'd4);
    check("dup_done_count", done_cnt, 32'd1);

    // Display disabled during PEND grants at once; enabling it mid-ACCESS
    // does not cut the slot short
    wait_seq(16);
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    check("pend_wait", {30'd0, cpu_wait, cpu_sel}, 32'd2);
    @(negedge clk);
    check("pend_hold", {30'd0, cpu_wait, cpu_sel}, 32'd2);
    video_enabled = 1'b0;
    @(negedge clk);
    check("late_grant_seq", {27'd0, clk_seq}, 32'd19);
    check("late_grant_sel", {31'd0, cpu_sel}, 32'd1);
    @(negedge clk);
    video_enabled = 1'b1;
    cpu_window(20, 24, 19, 22, 19, 22, "no_truncate");

    // Request with display fetch off is granted on the next clk
    video_enabled = 1'b0;
    wait_seq(20);
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_window(21, 27, 22, 25, 21, 25, "cpu_nodisp");
    wait_seq(0);
    scan(1'b1, 0, 31, "video_off");

    // Reset asserted in the middle of a CPU access
    video_enabled = 1'b1;
    wait_seq(3);
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    wait_seq(9);
    check("access_before_reset", {31'd0, cpu_sel}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_access", {18'd0, clk_seq, crtc_clk, vram_read, vram_read_char,
                               vram_read_att, charrom_read, disp_pipeline, cpu_sel,
                               cpu_wait, cpu_done}, 32'd0);
    @(negedge clk);
    check("reset_held_seq", {27'd0, clk_seq}, 32'd0);
    reset_n = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      check("restart_seq", {27'd0, clk_seq}, s);
      check("restart_cpu", {29'd0, cpu_wait, cpu_sel, cpu_done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
